router_pkt_receiver: RTL
========================

ROUTER_PKT_RECEIVER -- requirements
Module: router_pkt_receiver

Interface
REQ-001 Parameter PORT_ADDR, default 2'd1: router output port this instance drains; expected header address.
REQ-002 Parameter TIMEOUT, default 30: max idle cycles mid-packet before abort.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vld_out  in  1  router FIFO non-empty for this port.
REQ-006 data_out  in  8  router FIFO read data; valid one cycle after an accepted read.
REQ-007 read_enb  out  1  FIFO read request; a read is accepted on any edge where read_enb=1 and vld_out=1.
REQ-008 sink_ready  in  1  downstream ready; 0 stalls new reads.
REQ-009 byte_valid  out  1  one-cycle strobe: byte_data holds a received payload byte.
REQ-010 byte_data  out  8  payload byte.
REQ-011 pkt_done  out  1  one-cycle strobe at end of each complete packet.
REQ-012 pkt_len  out  6  payload length of last completed packet.
REQ-013 parity_err  out  1  valid with pkt_done: received parity mismatched.
REQ-014 addr_err  out  1  valid with pkt_done: header address != PORT_ADDR.
REQ-015 timeout_err  out  1  one-cycle strobe: packet aborted by timeout.
REQ-016 pkt_count  out  8  completed packets, wraps 255->0.
REQ-017 err_count  out  8  packets with parity_err, addr_err or timeout, saturates at 255.

Function
REQ-018 Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte = XOR of header and all payload bytes.
REQ-019 States: IDLE, HEADER, PAYLOAD, PARITY, DONE.
REQ-020 IDLE: read_enb = vld_out & sink_ready; first accepted read -> HEADER.
REQ-021 HEADER: no read issued; data_out captured as header; len=0 -> PARITY, else -> PAYLOAD.
REQ-022 PAYLOAD: read_enb = vld_out & sink_ready while issued payload+parity reads < len+1; exactly len+2 reads per packet, never more.
REQ-023 Each captured payload byte -> byte_valid=1, byte_data=byte, same cycle it is sampled (one cycle after its accepted read).
REQ-024 Parity byte captured after last payload byte -> DONE; byte_valid stays 0 for header and parity.
REQ-025 DONE (one cycle): pkt_done=1, pkt_len, parity_err, addr_err updated; pkt_count+1; err_count+1 if any error; -> IDLE; read_enb=0.
REQ-026 Running XOR register cleared in IDLE, loaded with header, XORed with each payload byte.
REQ-027 Timeout: in HEADER/PAYLOAD/PARITY, counter increments each cycle with no accepted read and no outstanding capture; reaching TIMEOUT -> timeout_err=1 one cycle, err_count+1, pkt_count unchanged, pkt_done not asserted, -> IDLE.
REQ-028 sink_ready low: no new reads; in-flight read still captured and byte_valid still pulsed; stall counts toward timeout only if vld_out=0.
REQ-029 Back-to-back packets: next header read may be accepted the cycle after DONE.
REQ-030 Max read throughput one byte/cycle in PAYLOAD; one bubble after header read.

Reset
REQ-031 reset=1 at a rising edge -> state IDLE, read_enb=0, byte_valid=0, byte_data=0, pkt_done=0, pkt_len=0, parity_err=0, addr_err=0, timeout_err=0, pkt_count=0, err_count=0, XOR and timeout counters 0.
REQ-032 Reset mid-packet discards the partial packet; no pkt_done or error strobe; outputs per REQ-031 the following cycle.

Verification
REQ-033 Header 0x39 (len 14, addr 1), 14 random bytes, correct parity, sink_ready=1 -> 14 byte_valid strobes in order, pkt_done with pkt_len=14, parity_err=0, addr_err=0, pkt_count=1.
REQ-034 Same packet, parity byte XOR 0x01 -> pkt_done, parity_err=1, err_count=1, pkt_count=1.
REQ-035 Header 0x51 (len 20), sink_ready toggled every 3 cycles -> exactly 22 accepted reads, 20 bytes in order, parity_err=0.
REQ-036 Header 0x02 (len 0, addr 2) with PORT_ADDR=1 -> no byte_valid, pkt_done, pkt_len=0, addr_err=1.
REQ-037 Header len 9, vld_out dropped after 4 payload bytes for 30 cycles -> timeout_err strobe, err_count=1, pkt_count=0, state IDLE.
REQ-038 Reset asserted after 5 payload bytes of a len-14 packet -> all outputs 0, next full packet received cleanly with pkt_count=1.

Source files
------------

// File: rtl/router_pkt_receiver.sv
// Router output-port packet receiver.
// Drains one FIFO port, strips header/parity, streams payload bytes.
module router_pkt_receiver #(
  parameter logic [1:0] PORT_ADDR = 2'd1,
  parameter int         TIMEOUT   = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  output logic       read_enb,
  input  logic       sink_ready,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       pkt_done,
  output logic [5:0] pkt_len,
  output logic       parity_err,
  output logic       addr_err,
  output logic       timeout_err,
  output logic [7:0] pkt_count,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    IDLE, HEADER, PAYLOAD, PARITY, DONE
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t state, state_n;

  logic [5:0]    len_q;
  logic [1:0]    addr_q;
  logic [6:0]    issued;
  logic [5:0]    captured;
  logic          pending;
  logic [7:0]    xor_q;
  logic [TW-1:0] tcnt;

  logic busy;
  logic more_reads;
  logic stall_cyc;
  logic any_err;

  assign busy = (state == HEADER) ||
                (state == PAYLOAD) ||
                (state == PARITY);

  // header read excluded: len payload reads plus one parity read
  assign more_reads = issued < ({1'b0, len_q} + 7'd1);

  // a sink stall with data waiting does not count as idle
  assign stall_cyc = busy && !pending && !vld_out;

  assign any_err = (xor_q != data_out) ||
                   (addr_q != PORT_ADDR);

  // next state, read request and strobes
  always_comb begin
    state_n     = state;
    read_enb    = 1'b0;
    byte_valid  = 1'b0;
    pkt_done    = 1'b0;
    timeout_err = 1'b0;
    unique case (state)
      IDLE: begin
        read_enb = vld_out && sink_ready;
        if (read_enb)
          state_n = HEADER;
      end
      HEADER: begin
        if (data_out[7:2] == 6'd0)
          state_n = PARITY;
        else
          state_n = PAYLOAD;
      end
      PAYLOAD: begin
        read_enb = vld_out && sink_ready && more_reads;
        if (pending) begin
          byte_valid = 1'b1;
          if (captured == len_q - 6'd1)
            state_n = PARITY;
        end
      end
      PARITY: begin
        read_enb = vld_out && sink_ready && more_reads;
        if (pending)
          state_n = DONE;
      end
      DONE: begin
        pkt_done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (stall_cyc && tcnt == TW'(TIMEOUT - 1)) begin
      timeout_err = 1'b1;
      state_n     = IDLE;
    end
  end

  assign byte_data = byte_valid ? data_out : 8'h00;

  // state, packet bookkeeping and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      issued     <= '0;
      captured   <= '0;
      pending    <= 1'b0;
      xor_q      <= '0;
      tcnt       <= '0;
      pkt_len    <= '0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      state   <= state_n;
      pending <= read_enb;
      if (!busy || pending || read_enb || timeout_err)
        tcnt <= '0;
      else if (stall_cyc)
        tcnt <= tcnt + TW'(1);
      unique case (state)
        IDLE: xor_q <= '0;
        HEADER: begin
          len_q    <= data_out[7:2];
          addr_q   <= data_out[1:0];
          xor_q    <= data_out;
          issued   <= '0;
          captured <= '0;
        end
        PAYLOAD: begin
          if (read_enb)
            issued <= issued + 7'd1;
          if (pending) begin
            xor_q    <= xor_q ^ data_out;
            captured <= captured + 6'd1;
          end
        end
        PARITY: begin
          if (read_enb)
            issued <= issued + 7'd1;
          if (pending) begin
            pkt_len    <= len_q;
            parity_err <= xor_q != data_out;
            addr_err   <= addr_q != PORT_ADDR;
            pkt_count  <= pkt_count + 8'd1;
            if (any_err && err_count != 8'hff)
              err_count <= err_count + 8'd1;
          end
        end
        default: ;
      endcase
      if (timeout_err && err_count != 8'hff)
        err_count <= err_count + 8'd1;
    end
  end

endmodule
